// File: rtl/cus_tag_pkg.sv
// ---------------------------------------------------------------------------
// cus_tag_pkg : shared constants and FSM state type for the custom-tag parser
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cus_tag_pkg;

  localparam int          TAG_OFFSET            = 12;
  localparam logic [15:0] CUS_TAG_ETHERTYPE_DEF = 16'h88B5;

  typedef enum logic [1:0] {
    S_HEAD  = 2'd0,
    S_BODY  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/axis_pair_buffer.sv
// ---------------------------------------------------------------------------
// axis_pair_buffer : two-entry FIFO carrying one packed stream beat per entry
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_pair_buffer #(
  parameter int WIDTH = 73
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             full_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  logic w_push;
  logic w_pop;

  assign full_o      = (count_q == 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

  assign w_push = in_valid_i & ~full_o;
  assign w_pop  = out_ready_i & out_valid_o;

  // Storage is reset too so that the outputs read zero while reset is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cus_tag_parser.sv
// ---------------------------------------------------------------------------
// cus_tag_parser : detects a custom ethertype tag and emits a per-packet route
//                  mask sideband; optional counters under CUS_TAG_STATS_EN
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cus_tag_parser
  import cus_tag_pkg::*;
#(
  parameter int          AXIS_BUS_WIDTH    = 64,
  parameter int          AXIS_ID_WIDTH     = 4,
  parameter logic [15:0] CUS_TAG_ETHERTYPE = CUS_TAG_ETHERTYPE_DEF,
  localparam int         NUM_AXIS_ID       = 2**AXIS_ID_WIDTH,
  localparam int         KEEP_W            = AXIS_BUS_WIDTH/8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [KEEP_W-1:0]         axis_in_tkeep,
  input  logic                      axis_in_tlast,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
  output logic [KEEP_W-1:0]         axis_out_tkeep,
  output logic                      axis_out_tlast,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  input  logic [NUM_AXIS_ID-1:0]    default_route_mask,
  output logic [NUM_AXIS_ID-1:0]    route_mask_out,
  output logic                      cus_tag_present
`ifdef CUS_TAG_STATS_EN
  ,
  output logic [31:0]               tagged_pkt_count,
  output logic [31:0]               untagged_pkt_count
`endif
);

  localparam int D_BEAT   = (AXIS_BUS_WIDTH == 64) ? 1 : 0;
  localparam int TAG_LANE = TAG_OFFSET - D_BEAT*KEEP_W;
  localparam int BUF_W    = AXIS_BUS_WIDTH + KEEP_W + 1;

  state_e                  state_q;
  logic                    beat_cnt_q;
  logic                    decided_q;
  logic                    tag_present_q;
  logic [NUM_AXIS_ID-1:0]  route_mask_q;

  logic                    tag_present_d;
  logic [NUM_AXIS_ID-1:0]  route_mask_d;

  logic                    w_accept;
  logic                    w_out_hs;
  logic                    w_is_d;
  logic [15:0]             w_etype;
  logic [15:0]             w_field;
  logic                    w_buf_full;
  logic                    w_buf_valid;
  logic [BUF_W-1:0]        w_buf_data;

  assign axis_in_tready = ~areset & ~w_buf_full & (state_q != S_DRAIN);
  assign w_accept       = axis_in_tvalid & axis_in_tready;

  assign {axis_out_tdata, axis_out_tkeep, axis_out_tlast} = w_buf_data;
  assign axis_out_tvalid = w_buf_valid & decided_q;
  assign w_out_hs        = axis_out_tvalid & axis_out_tready;

  assign route_mask_out  = route_mask_q;
  assign cus_tag_present = tag_present_q;

  axis_pair_buffer #(
    .WIDTH (BUF_W)
  ) u_buf (
    .clk_i       (aclk),
    .rst_i       (areset),
    .in_data_i   ({axis_in_tdata, axis_in_tkeep, axis_in_tlast}),
    .in_valid_i  (w_accept),
    .full_o      (w_buf_full),
    .out_data_o  (w_buf_data),
    .out_valid_o (w_buf_valid),
    .out_ready_i (axis_out_tready & decided_q)
  );

  // A short packet ending before the decision beat never matches: w_is_d is low.
  assign w_is_d  = (beat_cnt_q == 1'(D_BEAT));
  assign w_etype = {axis_in_tdata[TAG_LANE*8 +: 8],     axis_in_tdata[(TAG_LANE+1)*8 +: 8]};
  assign w_field = {axis_in_tdata[(TAG_LANE+2)*8 +: 8], axis_in_tdata[(TAG_LANE+3)*8 +: 8]};

  assign tag_present_d = w_is_d & (&axis_in_tkeep[TAG_LANE +: 4]) & (w_etype == CUS_TAG_ETHERTYPE);
  assign route_mask_d  = tag_present_d ? NUM_AXIS_ID'(w_field) : default_route_mask;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= S_HEAD;
      beat_cnt_q    <= 1'b0;
      decided_q     <= 1'b0;
      tag_present_q <= 1'b0;
      route_mask_q  <= '0;
    end else begin
      case (state_q)
        S_HEAD: begin
          if (w_accept) begin
            if (w_is_d || axis_in_tlast) begin
              decided_q     <= 1'b1;
              tag_present_q <= tag_present_d;
              route_mask_q  <= route_mask_d;
            end
            if (axis_in_tlast) begin
              state_q <= S_DRAIN;
            end else if (w_is_d) begin
              state_q <= S_BODY;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        S_BODY: begin
          if (w_accept && axis_in_tlast) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_hs && axis_out_tlast) begin
            state_q       <= S_HEAD;
            beat_cnt_q    <= 1'b0;
            decided_q     <= 1'b0;
            tag_present_q <= 1'b0;
            route_mask_q  <= '0;
          end
        end
        default: state_q <= S_HEAD;
      endcase
    end
  end

`ifdef CUS_TAG_STATS_EN
  logic [31:0] tagged_cnt_q;
  logic [31:0] untagged_cnt_q;

  assign tagged_pkt_count   = tagged_cnt_q;
  assign untagged_pkt_count = untagged_cnt_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tagged_cnt_q   <= '0;
      untagged_cnt_q <= '0;
    end else if (w_out_hs && axis_out_tlast) begin
      if (tag_present_q) begin
        if (tagged_cnt_q != 32'hFFFF_FFFF) tagged_cnt_q <= tagged_cnt_q + 32'd1;
      end else begin
        if (untagged_cnt_q != 32'hFFFF_FFFF) untagged_cnt_q <= untagged_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cus_tag_parser.sv
// ---------------------------------------------------------------------------
// tb_cus_tag_parser : randomized self-checking bench for cus_tag_parser
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cus_tag_parser;

  localparam int W   = 64;
  localparam int KW  = W/8;
  localparam int NID = 16;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic           tag;
    logic [NID-1:0] mask;
  } side_t;

  logic           aclk = 1'b0;
  logic           areset;
  logic [W-1:0]   axis_in_tdata;
  logic [KW-1:0]  axis_in_tkeep;
  logic           axis_in_tlast;
  logic           axis_in_tvalid;
  logic           axis_in_tready;
  logic [W-1:0]   axis_out_tdata;
  logic [KW-1:0]  axis_out_tkeep;
  logic           axis_out_tlast;
  logic           axis_out_tvalid;
  logic           axis_out_tready;
  logic [NID-1:0] default_route_mask;
  logic [NID-1:0] route_mask_out;
  logic           cus_tag_present;
`ifdef CUS_TAG_STATS_EN
  logic [31:0]    tagged_pkt_count;
  logic [31:0]    untagged_pkt_count;
`endif

  cus_tag_parser dut (
    .aclk               (aclk),
    .areset             (areset),
    .axis_in_tdata      (axis_in_tdata),
    .axis_in_tkeep      (axis_in_tkeep),
    .axis_in_tlast      (axis_in_tlast),
    .axis_in_tvalid     (axis_in_tvalid),
    .axis_in_tready     (axis_in_tready),
    .axis_out_tdata     (axis_out_tdata),
    .axis_out_tkeep     (axis_out_tkeep),
    .axis_out_tlast     (axis_out_tlast),
    .axis_out_tvalid    (axis_out_tvalid),
    .axis_out_tready    (axis_out_tready),
    .default_route_mask (default_route_mask),
    .route_mask_out     (route_mask_out),
    .cus_tag_present    (cus_tag_present)
`ifdef CUS_TAG_STATS_EN
    ,
    .tagged_pkt_count   (tagged_pkt_count),
    .untagged_pkt_count (untagged_pkt_count)
`endif
  );

  always #5 aclk = ~aclk;

  beat_t beat_q[$];
  side_t pkt_q[$];
  beat_t mon_b;
  int    n_checks = 0;
  int    n_errors = 0;
  int    acc_cnt = 0;
  bit    in_drain = 0;
  bit    tlast_acc = 0;
  bit    clear_pending = 0;
  int    out_mode = 0;
  int    exp_tagged = 0;
  int    exp_untagged = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output ready pattern: 0 = always, 1 = toggle, 2 = random.
  always @(posedge aclk) begin
    #1;
    case (out_mode)
      0:       axis_out_tready = 1'b1;
      1:       axis_out_tready = ~axis_out_tready;
      default: axis_out_tready = 1'($urandom);
    endcase
  end

  always @(negedge aclk) begin
    if (!areset) begin
      if (clear_pending) begin
        check_value("sideband_clear", {route_mask_out, cus_tag_present}, '0);
        clear_pending = 0;
      end
      if (in_drain) check_value("drain_tready", axis_in_tready, 0);
      if (axis_out_tvalid) begin
        if (pkt_q.size() == 0) begin
          check_value("spurious_valid", axis_out_tvalid, 0);
        end else begin
          check_value("early_valid", (acc_cnt >= 2 || tlast_acc), 1);
          check_value("tag_present", cus_tag_present, pkt_q[0].tag);
          check_value("route_mask", route_mask_out, pkt_q[0].mask);
          if (axis_out_tready) begin
            if (beat_q.size() == 0) begin
              check_value("extra_beat", 1, 0);
            end else begin
              mon_b = beat_q.pop_front();
              check_value("tdata", axis_out_tdata, mon_b.d);
              check_value("tkeep", axis_out_tkeep, mon_b.k);
              check_value("tlast", axis_out_tlast, mon_b.l);
              if (mon_b.l) begin
                if (pkt_q[0].tag) exp_tagged++;
                else exp_untagged++;
                void'(pkt_q.pop_front());
                clear_pending = 1;
                in_drain      = 0;
                acc_cnt       = 0;
                tlast_acc     = 0;
              end
            end
          end
        end
      end
      if (axis_in_tvalid && axis_in_tready) begin
        acc_cnt++;
        if (axis_in_tlast) begin
          in_drain  = 1;
          tlast_acc = 1;
        end
      end
    end
  end

  // Reference: tagged iff bytes 12..15 exist and 12..13 hold the ethertype.
  task automatic send_packet(input int len, input logic [15:0] etype, input logic [15:0] field,
                             input int max_beats, input bit gaps);
    logic [7:0] pb[$];
    side_t      s;
    beat_t      bt;
    int         nbeats;
    bit         got;
    for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
    if (len > 12) pb[12] = etype[15:8];
    if (len > 13) pb[13] = etype[7:0];
    if (len > 14) pb[14] = field[15:8];
    if (len > 15) pb[15] = field[7:0];
    s.tag  = 1'b0;
    s.mask = default_route_mask;
    if (len >= 16) begin
      if ({pb[12], pb[13]} == 16'h88B5) begin
        s.tag  = 1'b1;
        s.mask = {pb[14], pb[15]};
      end
    end
    pkt_q.push_back(s);
    nbeats = (len + KW - 1) / KW;
    for (int b = 0; b < nbeats && b < max_beats; b++) begin
      bt.d = {$urandom, $urandom};
      bt.k = '0;
      for (int l = 0; l < KW; l++) begin
        if (b*KW + l < len) begin
          bt.d[l*8 +: 8] = pb[b*KW + l];
          bt.k[l]        = 1'b1;
        end
      end
      bt.l = (b == nbeats - 1);
      beat_q.push_back(bt);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge aclk);
        #1;
      end
      axis_in_tdata  = bt.d;
      axis_in_tkeep  = bt.k;
      axis_in_tlast  = bt.l;
      axis_in_tvalid = 1'b1;
      got = 0;
      for (int t = 0; t < 2000 && !got; t++) begin
        @(negedge aclk);
        got = axis_in_tready;
        @(posedge aclk);
        #1;
      end
      if (!got) check_value("in_timeout", 0, 1);
      axis_in_tvalid = 1'b0;
    end
  endtask

  task automatic drain_wait();
    for (int t = 0; t < 2000 && pkt_q.size() != 0; t++) @(posedge aclk);
    #1;
    check_value("drain_done", pkt_q.size(), 0);
  endtask

  initial begin
    areset             = 1'b1;
    axis_in_tdata      = '0;
    axis_in_tkeep      = '0;
    axis_in_tlast      = 1'b0;
    axis_in_tvalid     = 1'b0;
    axis_out_tready    = 1'b0;
    default_route_mask = 16'h8001;
    repeat (3) @(posedge aclk);
    #1;
    check_value("rst_out_tvalid", axis_out_tvalid, 0);
    check_value("rst_out_tdata",  axis_out_tdata, 0);
    check_value("rst_out_tlast",  axis_out_tlast, 0);
    check_value("rst_in_tready",  axis_in_tready, 0);
    check_value("rst_mask",       route_mask_out, 0);
    check_value("rst_present",    cus_tag_present, 0);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check_value("post_rst_tready", axis_in_tready, 1);

    out_mode = 0;
    send_packet(24, 16'h88B5, 16'h0005, 99, 0);
    send_packet(40, 16'h0800, 16'h1234, 99, 0);
    send_packet(8,  16'h88B5, 16'h0001, 99, 0);
    drain_wait();
    out_mode = 1;
    send_packet(80, 16'h88B5, 16'h00A3, 99, 0);
    drain_wait();
    out_mode = 0;
    send_packet(32, 16'h88B5, 16'h7777, 99, 0);
    default_route_mask = 16'h0F0F;
    send_packet(20, 16'h0800, 16'h1111, 99, 0);
    send_packet(13, 16'h88B5, 16'h2222, 99, 0);
    send_packet(15, 16'h88B5, 16'h3333, 99, 0);
    send_packet(16, 16'h88B5, 16'h4444, 99, 0);
    drain_wait();

    for (int p = 0; p < 40; p++) begin
      default_route_mask = 16'($urandom);
      out_mode           = $urandom_range(0, 2);
      send_packet($urandom_range(1, 64), ($urandom_range(0, 1) == 1) ? 16'h88B5 : 16'($urandom),
                  16'($urandom), 99, 1);
    end
    drain_wait();

    out_mode = 0;
    send_packet(48, 16'h88B5, 16'h0042, 3, 0);
    @(posedge aclk);
    #2;
    areset = 1'b1;
    #1;
    check_value("mid_rst_out_tvalid", axis_out_tvalid, 0);
    check_value("mid_rst_out_tdata",  axis_out_tdata, 0);
    check_value("mid_rst_in_tready",  axis_in_tready, 0);
    check_value("mid_rst_sideband",   {route_mask_out, cus_tag_present}, 0);
    beat_q.delete();
    pkt_q.delete();
    acc_cnt       = 0;
    in_drain      = 0;
    tlast_acc     = 0;
    clear_pending = 0;
    exp_tagged    = 0;
    exp_untagged  = 0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
`ifdef CUS_TAG_STATS_EN
    check_value("rst_tagged_cnt",   tagged_pkt_count, 0);
    check_value("rst_untagged_cnt", untagged_pkt_count, 0);
`endif
    send_packet(24, 16'h88B5, 16'h0009, 99, 0);
    send_packet(16, 16'h0800, 16'h0009, 99, 0);
    drain_wait();
`ifdef CUS_TAG_STATS_EN
    check_value("tagged_cnt",   tagged_pkt_count, exp_tagged);
    check_value("untagged_cnt", untagged_pkt_count, exp_untagged);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
